// File: rtl/vm_dot_accum_if.sv
// rtl/vm_dot_accum_if.sv - product-in / result-out handshake bundle for vm_dot_accum
interface vm_dot_accum_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic [7:0]       prod;
  logic             prod_valid;
  logic             prod_last;
  logic             prod_ready;
  logic [ACC_W-1:0] res;
  logic [CNT_W-1:0] res_cnt;
  logic             res_ovf;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output prod, prod_valid, prod_last, res_ready,
    input  prod_ready, res, res_cnt, res_ovf, res_valid
  );

  modport slave (
    input  prod, prod_valid, prod_last, res_ready,
    output prod_ready, res, res_cnt, res_ovf, res_valid
  );
endinterface

// File: rtl/vm_dot_accum.sv
// rtl/vm_dot_accum.sv - dot-product accumulator behind the 4x4 Vedic multiplier
// Define VM_DOT_ACCUM_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module vm_dot_accum #(
  parameter int LEN   = 4,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  vm_dot_accum_if.slave  bus
);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;
  logic             last_elem;
  logic             accept;

  assign accept = bus.prod_valid & bus.prod_ready;

  always_comb begin
    sum       = {1'b0, acc} + (ACC_W+1)'(bus.prod);
    ovf_nxt   = ovf | sum[ACC_W];
`ifdef VM_DOT_ACCUM_SAT_EN
    // once overflowed, the vector stays pinned at full scale
    acc_nxt   = ovf_nxt ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_nxt   = sum[ACC_W-1:0];
`endif
    last_elem = bus.prod_last | (cnt == CNT_W'(LEN-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACC;
      acc            <= '0;
      cnt            <= '0;
      ovf            <= 1'b0;
      bus.res        <= '0;
      bus.res_cnt    <= '0;
      bus.res_ovf    <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.prod_ready <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          bus.prod_ready <= 1'b1;
          if (accept) begin
            if (last_elem) begin
              state          <= DONE;
              bus.res        <= acc_nxt;
              bus.res_cnt    <= cnt + 1'b1;
              bus.res_ovf    <= ovf_nxt;
              bus.res_valid  <= 1'b1;
              bus.prod_ready <= 1'b0;
            end else begin
              acc <= acc_nxt;
              cnt <= cnt + 1'b1;
              ovf <= ovf_nxt;
            end
          end
        end
        DONE: begin
          // result registers keep their value after the handshake
          if (bus.res_ready) begin
            state          <= ACC;
            acc            <= '0;
            cnt            <= '0;
            ovf            <= 1'b0;
            bus.res_valid  <= 1'b0;
            bus.prod_ready <= 1'b1;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
